// File: rtl/rr_resource_arbiter_pkg.sv
// Shared types and defaults for the round-robin resource arbiter slice.
package arb_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 16;
    localparam int ERR_W        = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } arb_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/rr_resource_arbiter_if.sv
// Request/grant and shared-resource handshake bundle for rr_resource_arbiter.
interface rr_resource_arbiter_if
    import arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_id;
    logic             res_start;
    logic             res_done;
    logic             timeout_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        input  req,
        input  res_done,
        output gnt,
        output gnt_id,
        output res_start,
        output timeout_err,
        output err_count
    );

    modport slave (
        output req,
        output res_done,
        input  gnt,
        input  gnt_id,
        input  res_start,
        input  timeout_err,
        input  err_count
    );

endinterface

// File: rtl/rr_resource_arbiter_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         pick_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);

    localparam int IDX_W = $clog2(N_REQ);

    always_comb begin
        int unsigned       cand_w;
        logic [IDX_W-1:0]  cand;
        logic              found;
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        cand_w = 0;
        cand   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // Wrap explicitly so the index stays in range for non-power-of-two N_REQ.
            cand_w = 32'(ptr_i) + i;
            if (cand_w >= N_REQ) begin
                cand_w = cand_w - N_REQ;
            end
            cand = cand_w[IDX_W-1:0];
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                pick_o[cand] = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter granting one requester at a time to a shared resource,
// with a start pulse, completion handshake and hold-timeout revocation.
module rr_resource_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_resource_arbiter_if.master bus
);

    localparam int                IDX_W     = $clog2(N_REQ);
    localparam int                HOLD_W    = 8;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  gnt_id_q, gnt_id_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              start_q, start_d;
    logic              terr_q, terr_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [N_REQ-1:0]  pick;
    logic [IDX_W-1:0]  pick_idx;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .pick_o(pick),
        .idx_o (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        start_d  = 1'b0;
        terr_d   = 1'b0;
        err_d    = err_q;
        hold_d   = hold_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d  = START;
                    gnt_d    = pick;
                    gnt_id_d = pick_idx;
                    start_d  = 1'b1;
                end
            end
            START: begin
                state_d = BUSY;
                hold_d  = '0;
            end
            BUSY: begin
                // Completion and timeout share the release path; done takes priority.
                if (bus.res_done || (hold_q == HOLD_LAST)) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    ptr_d    = (gnt_id_q == LAST_IDX) ? '0 : gnt_id_q + 1'b1;
                    if (!bus.res_done) begin
                        terr_d = 1'b1;
                        err_d  = sat_inc(err_q);
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            start_q  <= 1'b0;
            terr_q   <= 1'b0;
            err_q    <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            start_q  <= start_d;
            terr_q   <= terr_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.gnt_id      = gnt_id_q;
    assign bus.res_start   = start_q;
    assign bus.timeout_err = terr_q;
    assign bus.err_count   = err_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Self-checking bench for rr_resource_arbiter with a transaction-level reference model.
module tb_rr_resource_arbiter;
    import arb_pkg::*;

    localparam int NR = 4;
    localparam int MH = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   m_ptr;
    int   m_err;

    rr_resource_arbiter_if #(.N_REQ(NR)) bus ();

    rr_resource_arbiter #(
        .N_REQ   (NR),
        .MAX_HOLD(MH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference rule: first requester at or above ptr, else first from the bottom.
    function automatic int exp_owner(input logic [NR-1:0] r, input int p);
        for (int i = p; i < NR; i++) if (r[i]) return i;
        for (int i = 0; i < p; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req      = '0;
        bus.res_done = 1'b0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_ptr = 0;
        m_err = 0;
    endtask

    task automatic wait_start(output int n);
        n = -1;
        for (int c = 1; c <= 50; c++) begin
            cyc();
            if (bus.res_start === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    // Called in START; d = BUSY cycle carrying res_done (0 = never).
    task automatic run_busy(input int d, input bit drop, input bit done_in_start,
                            output int rel, output logic s2, output logic held,
                            output logic terr);
        logic [NR-1:0] g0;
        g0   = bus.gnt;
        rel  = -1;
        held = 1'b1;
        terr = 1'b0;
        if (done_in_start) bus.res_done = 1'b1;
        cyc();
        bus.res_done = 1'b0;
        s2 = bus.res_start;
        if (bus.gnt !== g0) held = 1'b0;
        if (drop) bus.req = '0;
        for (int c = 1; c <= MH + 4; c++) begin
            if (c == d) bus.res_done = 1'b1;
            cyc();
            bus.res_done = 1'b0;
            if (bus.gnt === '0) begin
                rel  = c;
                terr = bus.timeout_err;
                break;
            end
            if (bus.gnt !== g0) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b want 0", bus.gnt); end
        if (bus.gnt_id !== '0) begin errors++; $display("FAIL reset_gnt_id got %0d want 0", bus.gnt_id); end
        if (bus.res_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", bus.res_start); end
        if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got %b want 0", bus.timeout_err); end
        if (bus.err_count !== '0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", bus.err_count); end
        cyc();
        checks++;
        if (bus.gnt !== '0 || bus.res_start !== 1'b0) begin
            errors++; $display("FAIL idle_hold gnt %b start %b want 0 0", bus.gnt, bus.res_start);
        end
    endtask

    task automatic test_rr_sequence();
        int n, rel, exp;
        logic s2, held, terr;
        do_reset();
        bus.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp = t % NR;
            wait_start(n);
            checks += 3;
            if (n != 1) begin errors++; $display("FAIL seq_latency[%0d] got %0d want 1", t, n); end
            if (int'(bus.gnt_id) !== exp) begin errors++; $display("FAIL seq_id[%0d] got %0d want %0d", t, bus.gnt_id, exp); end
            if (bus.gnt !== (NR'(1) << exp)) begin errors++; $display("FAIL seq_gnt[%0d] got %b", t, bus.gnt); end
            run_busy(3, 1'b0, 1'b0, rel, s2, held, terr);
            checks += 4;
            if (s2 !== 1'b0) begin errors++; $display("FAIL seq_start_len[%0d] got %b want 0", t, s2); end
            if (held !== 1'b1) begin errors++; $display("FAIL seq_held[%0d] got %b want 1", t, held); end
            if (rel != 3) begin errors++; $display("FAIL seq_release[%0d] got %0d want 3", t, rel); end
            if (terr !== 1'b0 || bus.gnt_id !== '0) begin
                errors++; $display("FAIL seq_idle[%0d] terr %b id %0d want 0 0", t, terr, bus.gnt_id);
            end
            m_ptr = (exp + 1) % NR;
        end
        bus.req = '0;
    endtask

    task automatic test_single();
        int n, rel, own;
        logic s2, held, terr;
        do_reset();
        bus.req = 4'b0100;
        wait_start(n);
        checks += 2;
        if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", bus.gnt); end
        if (int'(bus.gnt_id) !== 2) begin errors++; $display("FAIL single_id got %0d want 2", bus.gnt_id); end
        run_busy(5, 1'b1, 1'b0, rel, s2, held, terr);
        checks += 2;
        if (s2 !== 1'b0) begin errors++; $display("FAIL single_start_len got %b want 0", s2); end
        if (rel != 5) begin errors++; $display("FAIL single_release got %0d want 5", rel); end
        m_ptr = 3;
        bus.req = 4'b1001;
        own = exp_owner(4'b1001, m_ptr);
        wait_start(n);
        checks += 2;
        if (int'(bus.gnt_id) !== own) begin errors++; $display("FAIL next_id got %0d want %0d", bus.gnt_id, own); end
        if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL next_gnt got %b want 1000", bus.gnt); end
        run_busy(2, 1'b1, 1'b0, rel, s2, held, terr);
        checks++;
        if (rel != 2) begin errors++; $display("FAIL next_release got %0d want 2", rel); end
    endtask

    task automatic test_timeout();
        int n, rel, own;
        logic s2, held, terr;
        logic [NR-1:0] r;
        do_reset();
        for (int i = 0; i < 260; i++) begin
            r = NR'($urandom_range(1, 15));
            bus.req = r;
            own = exp_owner(r, m_ptr);
            wait_start(n);
            checks += 2;
            if (n != 1) begin errors++; $display("FAIL to_latency[%0d] got %0d want 1", i, n); end
            if (int'(bus.gnt_id) !== own) begin errors++; $display("FAIL to_id[%0d] got %0d want %0d", i, bus.gnt_id, own); end
            run_busy(0, 1'($urandom_range(0, 1)), 1'b0, rel, s2, held, terr);
            m_ptr = (own + 1) % NR;
            m_err = (m_err < 255) ? m_err + 1 : 255;
            checks += 4;
            if (rel != MH) begin errors++; $display("FAIL to_release[%0d] got %0d want %0d", i, rel, MH); end
            if (terr !== 1'b1) begin errors++; $display("FAIL to_pulse[%0d] got %b want 1", i, terr); end
            if (held !== 1'b1) begin errors++; $display("FAIL to_held[%0d] got %b want 1", i, held); end
            if (int'(bus.err_count) !== m_err) begin
                errors++; $display("FAIL to_errcnt[%0d] got %0d want %0d", i, bus.err_count, m_err);
            end
            if (i == 0) begin
                bus.req = '0;
                cyc();
                checks++;
                if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_single_pulse got %b want 0", bus.timeout_err); end
            end
        end
        bus.req = '0;
        checks++;
        if (bus.err_count !== 8'd255) begin errors++; $display("FAIL to_saturate got %0d want 255", bus.err_count); end
    endtask

    task automatic test_boundary();
        int n, rel;
        logic s2, held, terr;
        do_reset();
        bus.req = 4'b0001;
        wait_start(n);
        run_busy(0, 1'b1, 1'b0, rel, s2, held, terr);
        m_err = 1;
        bus.req = 4'b0010;
        wait_start(n);
        checks++;
        if (int'(bus.gnt_id) !== 1) begin errors++; $display("FAIL bnd_id got %0d want 1", bus.gnt_id); end
        run_busy(MH, 1'b1, 1'b0, rel, s2, held, terr);
        checks += 4;
        if (rel != MH) begin errors++; $display("FAIL bnd_release got %0d want %0d", rel, MH); end
        if (terr !== 1'b0) begin errors++; $display("FAIL bnd_terr got %b want 0", terr); end
        if (held !== 1'b1) begin errors++; $display("FAIL bnd_held got %b want 1", held); end
        if (int'(bus.err_count) !== m_err) begin errors++; $display("FAIL bnd_errcnt got %0d want %0d", bus.err_count, m_err); end
        cyc();
        checks++;
        if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL bnd_terr_next got %b want 0", bus.timeout_err); end
    endtask

    task automatic test_reset_mid();
        int n, rel;
        logic s2, held, terr;
        do_reset();
        bus.req = 4'b0001;
        wait_start(n);
        run_busy(0, 1'b1, 1'b0, rel, s2, held, terr);
        bus.req = 4'b0010;
        wait_start(n);
        checks++;
        if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rm_gnt got %b want 0010", bus.gnt); end
        bus.req = '0;
        repeat (3) cyc();
        #2 rst = 1'b1;
        #1;
        checks += 5;
        if (bus.gnt !== '0) begin errors++; $display("FAIL rm_gnt_clr got %b want 0", bus.gnt); end
        if (bus.gnt_id !== '0) begin errors++; $display("FAIL rm_id_clr got %0d want 0", bus.gnt_id); end
        if (bus.res_start !== 1'b0) begin errors++; $display("FAIL rm_start_clr got %b want 0", bus.res_start); end
        if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rm_terr_clr got %b want 0", bus.timeout_err); end
        if (bus.err_count !== '0) begin errors++; $display("FAIL rm_err_clr got %0d want 0", bus.err_count); end
        @(posedge clk);
        #1 rst = 1'b0;
        m_ptr = 0;
        m_err = 0;
        bus.req = 4'b0011;
        wait_start(n);
        checks += 2;
        if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL rm_regrant got %b want 0001", bus.gnt); end
        if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rm_no_terr got %b want 0", bus.timeout_err); end
        run_busy(2, 1'b1, 1'b0, rel, s2, held, terr);
    endtask

    task automatic test_ignore_done();
        int n, rel;
        logic s2, held, terr;
        do_reset();
        bus.res_done = 1'b1;
        cyc();
        bus.res_done = 1'b0;
        checks++;
        if (bus.gnt !== '0 || bus.res_start !== 1'b0 || bus.timeout_err !== 1'b0) begin
            errors++; $display("FAIL ign_idle gnt %b start %b terr %b want 0", bus.gnt, bus.res_start, bus.timeout_err);
        end
        bus.req = 4'b1000;
        wait_start(n);
        checks++;
        if (int'(bus.gnt_id) !== exp_owner(4'b1000, m_ptr)) begin errors++; $display("FAIL ign_id got %0d want 3", bus.gnt_id); end
        run_busy(6, 1'b1, 1'b1, rel, s2, held, terr);
        checks += 4;
        if (s2 !== 1'b0) begin errors++; $display("FAIL ign_start got %b want 0", s2); end
        if (held !== 1'b1) begin errors++; $display("FAIL ign_held got %b want 1", held); end
        if (rel != 6) begin errors++; $display("FAIL ign_release got %0d want 6", rel); end
        if (bus.err_count !== '0) begin errors++; $display("FAIL ign_errcnt got %0d want 0", bus.err_count); end
    endtask

    task automatic test_random();
        int n, rel, own, d, exp_rel;
        logic s2, held, terr;
        logic [NR-1:0] r;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            r = NR'($urandom_range(1, 15));
            d = $urandom_range(1, MH + 4);
            bus.req = r;
            own = exp_owner(r, m_ptr);
            wait_start(n);
            checks += 2;
            if (n != 1) begin errors++; $display("FAIL rnd_latency[%0d] got %0d want 1", i, n); end
            if (bus.gnt !== (NR'(1) << own)) begin errors++; $display("FAIL rnd_gnt[%0d] got %b want owner %0d", i, bus.gnt, own); end
            run_busy(d, 1'($urandom_range(0, 1)), 1'b0, rel, s2, held, terr);
            exp_rel = (d <= MH) ? d : MH;
            m_ptr = (own + 1) % NR;
            if (d > MH) m_err = (m_err < 255) ? m_err + 1 : 255;
            checks += 4;
            if (rel != exp_rel) begin errors++; $display("FAIL rnd_release[%0d] got %0d want %0d", i, rel, exp_rel); end
            if (terr !== (d > MH)) begin errors++; $display("FAIL rnd_terr[%0d] got %b want %b", i, terr, d > MH); end
            if (held !== 1'b1 || s2 !== 1'b0) begin errors++; $display("FAIL rnd_hold[%0d] held %b start %b want 1 0", i, held, s2); end
            if (int'(bus.err_count) !== m_err) begin errors++; $display("FAIL rnd_errcnt[%0d] got %0d want %0d", i, bus.err_count, m_err); end
        end
        bus.req = '0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.req      = '0;
        bus.res_done = 1'b0;
        test_reset();
        test_rr_sequence();
        test_single();
        test_boundary();
        test_reset_mid();
        test_ignore_done();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_resource_arbiter.md
RR_RESOURCE_ARBITER -- requirements
Module: rr_resource_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 16: maximum cycles in BUSY awaiting res_done; legal range 2..255.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req  input  N_REQ  per-requester level request; requester i holds req[i] high until it sees gnt[i].
REQ-006 gnt  output  N_REQ  one-hot grant; all zero when no owner.
REQ-007 gnt_id  output  $clog2(N_REQ)  binary index of the current owner; 0 when no owner.
REQ-008 res_start  output  1  single-cycle pulse that starts the shared resource.
REQ-009 res_done  input  1  single-cycle completion pulse from the shared resource.
REQ-010 timeout_err  output  1  single-cycle pulse when a grant is revoked by timeout.
REQ-011 err_count  output  8  saturating count of timeouts since reset.

Function
REQ-012 The FSM SHALL have three states: IDLE, START and BUSY; all outputs SHALL be registered.
REQ-013 In IDLE with req != 0, the next edge SHALL select the first set req bit at or above index ptr, wrapping modulo N_REQ; it SHALL set gnt/gnt_id to that index, assert res_start and enter START.
REQ-014 In IDLE with req == 0, the state, gnt and ptr SHALL hold.
REQ-015 START SHALL last exactly one cycle; the next edge SHALL deassert res_start and enter BUSY.
REQ-016 Latency: req sampled at edge k in IDLE -> gnt and res_start high after edge k; res_start low after edge k+1.
REQ-017 On entry to BUSY, the hold timer SHALL clear; it SHALL increment on each BUSY cycle without res_done.
REQ-018 In BUSY, res_done=1 SHALL return to IDLE at the next edge: gnt=0, gnt_id=0, ptr=(owner+1) mod N_REQ.
REQ-019 In BUSY, when MAX_HOLD consecutive BUSY cycles pass without res_done, the next edge SHALL:
- return to IDLE with the same gnt and ptr update as REQ-018;
- pulse timeout_err for one cycle;
- increment err_count, saturating at 255.
REQ-020 res_done and the timeout condition in the same cycle: done wins; no timeout_err, no err_count change.
REQ-021 res_done in IDLE or START SHALL be ignored.
REQ-022 Owner deasserting req during START/BUSY SHALL NOT revoke the grant; release only per REQ-018/REQ-019.
REQ-023 Requests arriving during START/BUSY SHALL be considered only at the next IDLE arbitration.
REQ-024 Back-to-back grants SHALL be separated by at least one IDLE cycle with gnt=0.
REQ-025 At most one gnt bit SHALL ever be high.

Reset
REQ-026 rst=1 SHALL immediately force:
- state=IDLE, gnt=0, gnt_id=0, res_start=0, timeout_err=0;
- err_count=0, ptr=0, hold timer=0.
REQ-027 Reset during START or BUSY SHALL abort the grant with no timeout_err pulse; arbitration SHALL resume from ptr=0 after release.

Structure
REQ-028 A shared package arb_pkg SHALL hold:
- the state enum typedef (IDLE, START, BUSY);
- default constants N_REQ_DEF=4, MAX_HOLD_DEF=16, ERR_W=8.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_pick; its inputs are req and ptr, and its outputs are a one-hot pick and a binary index.

Verification (N_REQ=4, MAX_HOLD=16)
REQ-030 After reset, req=4'b1111 held, res_done 3 cycles after each res_start -> grants go to 0,1,2,3,0 in order, with one IDLE cycle between grants.
REQ-031 req=4'b0100 only -> gnt=4'b0100, gnt_id=2, res_start high for exactly one cycle; res_done -> gnt=0 next cycle, and the next grant goes to requester 3 if it requests.
REQ-032 Grant held and res_done never arrives -> after 16 BUSY cycles: timeout_err pulses once, err_count=1, gnt=0; repeated 260 times -> err_count=255.
REQ-033 res_done on the 16th BUSY cycle (timeout boundary) -> normal release, timeout_err=0, err_count unchanged.
REQ-034 rst asserted mid-BUSY with gnt=4'b0010 -> all outputs 0 immediately; after release with req=4'b0011, the grant goes to requester 0.
REQ-035 res_done pulsed in IDLE and in START -> no state change; the owner deasserts req in BUSY -> the grant persists until res_done.
